// File: rtl/vec_loader.sv
`default_nettype none
// ============================================================================
// Module      : vec_loader
// Description : Ping-pong operand packer feeding the vecmul dot-product stage.
//               Serial (a, b) pairs arrive over a valid/ready handshake and
//               are packed lane by lane into one of two buffers.  A full
//               buffer is copied to in1/in2 with a one-cycle en strobe.  The
//               next issue waits for done or for a drain timeout.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   VSIZE        elements per vector (must match vecmul), >= 1
//   DRAIN_CYCLES max WAIT cycles before an issue is released without done, >= 1
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   s_valid      upstream pair valid
//   s_ready      loader can take a pair this cycle
//   s_a, s_b     vector 1 / vector 2 element bits (copied untouched)
//   s_last       last pair of the current vector; remaining lanes zeroed
//   in1, in2     packed vectors presented to vecmul
//   en           one-cycle issue strobe
//   done         completion pulse from vecmul
//   busy         a buffer is full or an issue is outstanding
//   timeout_cnt  saturating count of issues released by timeout
// ============================================================================
module vec_loader #(
  parameter int VSIZE        = 4,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [31:0]            s_a,
  input  logic [31:0]            s_b,
  input  logic                   s_last,
  output logic [VSIZE-1:0][31:0] in1,
  output logic [VSIZE-1:0][31:0] in2,
  output logic                   en,
  input  logic                   done,
  output logic                   busy,
  output logic [15:0]            timeout_cnt
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int IDX_W = (VSIZE > 1) ? $clog2(VSIZE) : 1;
  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(VSIZE - 1);
  localparam logic [CNT_W-1:0] c_drain    = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [15:0]      c_tcnt_max = 16'hFFFF;

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_wait = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0][VSIZE-1:0][31:0] r_buf1;      // vector 1 storage, buffer A/B
  logic [1:0][VSIZE-1:0][31:0] r_buf2;      // vector 2 storage, buffer A/B
  logic [1:0]                  r_full;      // per-buffer full flag
  logic                        r_fill_ptr;  // buffer currently being filled
  logic                        r_issue_ptr; // buffer next to be issued
  logic [IDX_W-1:0]            r_idx;       // next lane to write
  logic [0:0]                  r_state;
  logic [CNT_W-1:0]            r_cnt;       // remaining WAIT cycles
  logic [VSIZE-1:0][31:0]      r_in1;
  logic [VSIZE-1:0][31:0]      r_in2;
  logic                        r_en;
  logic [15:0]                 r_tcnt;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic             w_ready;
  logic             w_accept;
  logic             w_close;
  logic             w_issue;
  logic             w_expire;
  logic             w_release;
  logic             w_timeout;
  logic [1:0]       w_full_nxt;
  logic [VSIZE-1:0] w_lane_wr;
  logic [VSIZE-1:0] w_lane_clr;

  // The fill buffer is never the one in flight unless both are full, so its
  // own full flag is the whole backpressure condition.
  assign w_ready  = !r_full[r_fill_ptr];
  assign w_accept = s_valid && w_ready;
  assign w_close  = w_accept && ((r_idx == c_idx_last) || s_last);

  assign w_issue   = (r_state == c_st_idle) && r_full[r_issue_ptr];
  // r_cnt == 1 marks the last WAIT cycle; done in that cycle takes priority
  // so the release is not charged as a timeout.
  assign w_expire  = (r_state == c_st_wait) && (r_cnt == c_cnt_one);
  assign w_release = (r_state == c_st_wait) && (done || (r_cnt == c_cnt_one));
  assign w_timeout = w_expire && !done;

  // Release and close always target different buffers when they coincide,
  // so applying both to one next-state vector keeps both updates.
  always_comb begin
    w_full_nxt = r_full;
    if (w_release) begin
      w_full_nxt[r_issue_ptr] = 1'b0;
    end
    if (w_close) begin
      w_full_nxt[r_fill_ptr] = 1'b1;
    end
  end

  // Lane enables: write the lane at idx; on a close also zero every lane
  // above it so a short vector leaves no stale operands behind.
  always_comb begin
    w_lane_wr  = '0;
    w_lane_clr = '0;
    for (int i = 0; i < VSIZE; i++) begin
      w_lane_wr[i]  = w_accept && (r_idx == IDX_W'(i));
      w_lane_clr[i] = w_close && (IDX_W'(i) > r_idx);
    end
  end

  // --------------------------------------------------------------------------
  // Fill side
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf1 <= '0;
      r_buf2 <= '0;
    end else begin
      for (int i = 0; i < VSIZE; i++) begin
        if (w_lane_wr[i]) begin
          r_buf1[r_fill_ptr][i] <= s_a;
          r_buf2[r_fill_ptr][i] <= s_b;
        end else if (w_lane_clr[i]) begin
          r_buf1[r_fill_ptr][i] <= '0;
          r_buf2[r_fill_ptr][i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_fill_ptr <= 1'b0;
    end else if (w_close) begin
      r_idx      <= '0;
      r_fill_ptr <= !r_fill_ptr;
    end else if (w_accept) begin
      r_idx      <= r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
    end else begin
      r_full <= w_full_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Issue FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_issue_ptr <= 1'b0;
      r_cnt       <= '0;
      r_en        <= 1'b0;
      r_in1       <= '0;
      r_in2       <= '0;
    end else begin
      r_en <= 1'b0;
      case (r_state)
        c_st_idle: begin
          // A done seen here is stray and has no effect.
          if (w_issue) begin
            r_in1   <= r_buf1[r_issue_ptr];
            r_in2   <= r_buf2[r_issue_ptr];
            r_en    <= 1'b1;
            r_cnt   <= c_drain;
            r_state <= c_st_wait;
          end
        end
        c_st_wait: begin
          if (w_release) begin
            r_issue_ptr <= !r_issue_ptr;
            r_state     <= c_st_idle;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if (w_timeout && (r_tcnt != c_tcnt_max)) begin
      r_tcnt <= r_tcnt + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_ready     = w_ready;
  assign in1         = r_in1;
  assign in2         = r_in2;
  assign en          = r_en;
  assign busy        = r_full[0] | r_full[1] | (r_state == c_st_wait);
  assign timeout_cnt = r_tcnt;

endmodule
`default_nettype wire
